// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the ALU/MDU block.
// Pure type definitions: no latency or flow control here.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_LUI  = 4'd4,
    OP_SLTU = 4'd5,
    OP_MULU = 4'd6,
    OP_DIVU = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIV  = 4'd9,
    OP_SLT  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_iter.sv
// Unsigned shift-add multiply / restoring divide, WIDTH iterations; the first runs on the start edge.
// No backpressure: done_o stays high and {hi_o,lo_o} stay frozen until the next start_i.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;

  logic             cur_div;
  logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             step;

  // On start the step works straight from the ports, so the result lands WIDTH edges later.
  always_comb begin
    cur_div  = start_i ? div_i : div_q;
    cur_hi   = start_i ? '0 : hi_q;
    cur_lo   = start_i ? (div_i ? a_i : b_i) : lo_q;
    cur_m    = start_i ? (div_i ? b_i : a_i) : m_q;
    mul_sum  = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_m} : '0);
    rem_sh   = {cur_hi, cur_lo[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, cur_m};
    if (cur_div) begin
      if (rem_diff[WIDTH]) begin
        hi_d = rem_sh[WIDTH-1:0];
        lo_d = {cur_lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = rem_diff[WIDTH-1:0];
        lo_d = {cur_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  assign step   = start_i || (cnt_q != '0 && cnt_q != CW'(WIDTH));
  assign done_o = (cnt_q == CW'(WIDTH));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
    end else if (step) begin
      cnt_q <= start_i ? CW'(1) : cnt_q + CW'(1);
      div_q <= cur_div;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= cur_m;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// ALU + iterative MDU: 1-cycle ops valid next cycle, MUL/DIV after WIDTH+1; result held until out_ready.
// ALU_MDU_SIGNED_EN adds signed MUL/DIV/SLT; in_ready is high in IDLE, or in HOLD while out_ready.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [2:0]       cmp
);
  localparam int HALF = WIDTH / 2;

  state_e           state_q;
  logic             rdy_en_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic [2:0]       cmp_q;
  logic             is_div_q, neg_lo_q, neg_hi_q;

  logic [WIDTH-1:0] fast_d, mdu_a_d, mdu_b_d;
  logic             mdu_go_d, is_div_d, neg_lo_d, neg_hi_d;
  logic [2:0]       cmp_d;
  logic             accept;

  logic             mdu_done;
  logic [WIDTH-1:0] mdu_hi, mdu_lo, hi_fix, lo_fix;

  always_comb begin
    fast_d   = a + b;
    mdu_go_d = 1'b0;
    is_div_d = 1'b0;
    mdu_a_d  = a;
    mdu_b_d  = b;
    neg_lo_d = 1'b0;
    neg_hi_d = 1'b0;
    case (op)
      OP_SUB:  fast_d = a - b;
      OP_AND:  fast_d = a & b;
      OP_OR:   fast_d = a | b;
      OP_LUI:  fast_d = {b[HALF-1:0], {HALF{1'b0}}};
      OP_SLTU: fast_d = {{(WIDTH-1){1'b0}}, a < b};
      OP_MULU: mdu_go_d = 1'b1;
      OP_DIVU: begin
        mdu_go_d = 1'b1;
        is_div_d = 1'b1;
      end
`ifdef ALU_MDU_SIGNED_EN
      OP_SLT:  fast_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      // Signed ops run on magnitudes; the sign is restored when the result is captured.
      OP_MUL: begin
        mdu_go_d = 1'b1;
        mdu_a_d  = a[WIDTH-1] ? -a : a;
        mdu_b_d  = b[WIDTH-1] ? -b : b;
        neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
      end
      OP_DIV: begin
        mdu_go_d = 1'b1;
        is_div_d = 1'b1;
        if (b != '0) begin
          mdu_a_d  = a[WIDTH-1] ? -a : a;
          mdu_b_d  = b[WIDTH-1] ? -b : b;
          neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_hi_d = a[WIDTH-1];
        end
      end
`endif
      default: ;
    endcase
  end

  assign cmp_d     = {a > b, a == b, a < b};
  assign in_ready  = rdy_en_q && (state_q == ST_IDLE || (state_q == ST_HOLD && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign hi        = hi_q;
  assign cmp       = cmp_q;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && mdu_go_d),
    .div_i   (is_div_d),
    .a_i     (mdu_a_d),
    .b_i     (mdu_b_d),
    .done_o  (mdu_done),
    .hi_o    (mdu_hi),
    .lo_o    (mdu_lo)
  );

  always_comb begin
    lo_fix = mdu_lo;
    hi_fix = mdu_hi;
    if (!is_div_q && neg_lo_q) begin
      {hi_fix, lo_fix} = -{mdu_hi, mdu_lo};
    end else begin
      if (neg_lo_q) lo_fix = -mdu_lo;
      if (neg_hi_q) hi_fix = -mdu_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      cmp_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (state_q == ST_CALC) begin
        if (mdu_done) begin
          state_q  <= ST_HOLD;
          result_q <= lo_fix;
          hi_q     <= hi_fix;
        end
      end else if (accept) begin
        cmp_q    <= cmp_d;
        is_div_q <= is_div_d;
        neg_lo_q <= neg_lo_d;
        neg_hi_q <= neg_hi_d;
        if (mdu_go_d) begin
          state_q <= ST_CALC;
        end else begin
          state_q  <= ST_HOLD;
          result_q <= fast_d;
          hi_q     <= '0;
        end
      end else if (state_q == ST_HOLD && out_ready) begin
        state_q <= ST_IDLE;
      end
    end
  end

endmodule
